// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity modes and limits for the UART transceiver.
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE3 = 2'b11
    } parity_mode_t;

    localparam int UART_MIN_DIV = 4;

    function automatic logic par_en(input logic [1:0] mode);
        return mode == PAR_EVEN || mode == PAR_ODD;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with show-ahead read data.
// Ports: clk, resetn (async, active-low), push/wdata, pop/rdata, full, empty.
// Pushes while full and pops while empty are ignored; rdata reads 0 when empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;

    // Extra pointer bit tells full from empty when the indices coincide.
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk)
        if (push && !full) mem[wp[AW-1:0]] <= wdata;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: UART transceiver with TX/RX FIFOs, run-time divisor and error pulses.
// Ports: clk, resetn (async, active-low), divisor, tx_data/tx_valid/tx_ready,
// rx_data/rx_valid/rx_ready, ser_txd, ser_rxd, tx_busy, rx_frame_err, rx_overrun.
// UART_XCVR_PARITY_EN adds parity_mode[1:0] (00/11 none, 01 even, 10 odd) and rx_parity_err.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [DIV_W-1:0]     divisor,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 ser_txd,
    input  logic                 ser_rxd,
    output logic                 tx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
`ifdef UART_XCVR_PARITY_EN
    ,
    input  logic [1:0]           parity_mode,
    output logic                 rx_parity_err
`endif
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    logic [1:0]       pmode;
    logic [DIV_W-1:0] div_eff;

`ifdef UART_XCVR_PARITY_EN
    assign pmode = parity_mode;
`else
    assign pmode = 2'b00;
`endif
    assign div_eff = (divisor < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : divisor;

    uart_state_t          tx_state, tx_next;
    logic                 tx_empty, tx_full, tx_pop, tx_tick, tx_par, tx_pen, tx_on, tx_line;
    logic [DATA_BITS-1:0] tx_head, tx_sh;
    logic [DIV_W-1:0]     tx_div, tx_cnt;
    logic [BW-1:0]        tx_bit;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .resetn(resetn), .push(tx_valid), .pop(tx_pop), .wdata(tx_data),
        .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    assign tx_ready = ~tx_full;
    assign tx_tick  = tx_cnt == '0;
    assign tx_pop   = tx_state == ST_IDLE && !tx_empty;
    assign tx_busy  = tx_on || tx_state != ST_IDLE || !tx_empty;
    assign tx_line  = tx_state == ST_START  ? 1'b0 :
                      tx_state == ST_DATA   ? tx_sh[0] :
                      tx_state == ST_PARITY ? tx_par : 1'b1;

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            ST_IDLE:   if (!tx_empty) tx_next = ST_START;
            ST_START:  if (tx_tick) tx_next = ST_DATA;
            ST_DATA:   if (tx_tick && tx_bit == LAST) tx_next = tx_pen ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tx_tick) tx_next = ST_STOP;
            default:   if (tx_tick) tx_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) tx_state <= ST_IDLE;
        else tx_state <= tx_next;

    // The line is registered from the state, so every bit lasts exactly tx_div
    // cycles and a reset drives the pin high without waiting for a clock.
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            ser_txd <= 1'b1;
            tx_on   <= 1'b0;
            tx_sh   <= '0;
            tx_div  <= '0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_par  <= 1'b0;
            tx_pen  <= 1'b0;
        end else begin
            ser_txd <= tx_line;
            tx_on   <= tx_state != ST_IDLE;
            if (tx_pop) begin
                tx_sh  <= tx_head;
                tx_div <= div_eff;
                tx_cnt <= div_eff - 1'b1;
                tx_bit <= '0;
                tx_pen <= par_en(pmode);
                tx_par <= ^tx_head ^ (pmode == PAR_ODD);
            end else if (tx_state != ST_IDLE) begin
                tx_cnt <= tx_tick ? tx_div - 1'b1 : tx_cnt - 1'b1;
                if (tx_tick && tx_state == ST_DATA) begin
                    tx_sh  <= tx_sh >> 1;
                    tx_bit <= tx_bit + 1'b1;
                end
            end
        end

    uart_state_t          rx_state, rx_next;
    logic                 rx_s1, rx_s2, rx_s3, rx_brk, rx_tick, rx_fall, rx_stop_hit, rx_push;
    logic                 rx_full, rx_empty;
    logic [DATA_BITS-1:0] rx_sh;
    logic [DIV_W-1:0]     rx_div, rx_cnt;
    logic [BW-1:0]        rx_bit;
    logic [1:0]           rx_pm;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .resetn(resetn), .push(rx_push), .pop(rx_ready), .wdata(rx_sh),
        .rdata(rx_data), .full(rx_full), .empty(rx_empty)
    );

    assign rx_valid    = ~rx_empty;
    assign rx_tick     = rx_cnt == '0;
    assign rx_fall     = rx_s3 && !rx_s2;
    // rx_brk marks a stop bit already judged low, so the break wait raises no more events.
    assign rx_stop_hit = rx_state == ST_STOP && rx_tick && !rx_brk;
    assign rx_push     = rx_stop_hit && rx_s2 && !rx_full;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            ST_IDLE:   if (rx_fall) rx_next = ST_START;
            ST_START:  if (rx_tick) rx_next = rx_s2 ? ST_IDLE : ST_DATA;
            ST_DATA:   if (rx_tick && rx_bit == LAST) rx_next = par_en(rx_pm) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (rx_tick) rx_next = ST_STOP;
            default:   if (rx_s2 && (rx_brk || rx_tick)) rx_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) rx_state <= ST_IDLE;
        else rx_state <= rx_next;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_s3        <= 1'b1;
            rx_brk       <= 1'b0;
            rx_sh        <= '0;
            rx_div       <= '0;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_pm        <= 2'b00;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_s1        <= ser_rxd;
            rx_s2        <= rx_s1;
            rx_s3        <= rx_s2;
            rx_frame_err <= rx_stop_hit && !rx_s2;
            rx_overrun   <= rx_stop_hit && rx_s2 && rx_full;
            if (rx_state == ST_IDLE) begin
                rx_brk <= 1'b0;
                if (rx_fall) begin
                    rx_div <= div_eff;
                    rx_cnt <= div_eff >> 1;
                    rx_bit <= '0;
                    rx_pm  <= pmode;
                end
            end else if (rx_tick) begin
                rx_cnt <= rx_div - 1'b1;
                if (rx_state == ST_DATA) begin
                    rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                    rx_bit <= rx_bit + 1'b1;
                end
                if (rx_stop_hit && !rx_s2) rx_brk <= 1'b1;
            end else begin
                rx_cnt <= rx_cnt - 1'b1;
            end
        end

`ifdef UART_XCVR_PARITY_EN
    logic rx_pbit;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            rx_pbit       <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            if (rx_state == ST_PARITY && rx_tick) rx_pbit <= rx_s2;
            rx_parity_err <= rx_stop_hit && par_en(rx_pm) &&
                             ((^rx_sh ^ rx_pbit) != (rx_pm == PAR_ODD));
        end
`endif
endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: scoreboard bench for uart_xcvr (TX waveform, loopback, RX error paths).
module tb_uart_xcvr;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] divisor = 16'd430;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        ser_txd, ser_rxd, tx_busy, rx_frame_err, rx_overrun;
    logic        lb = 1'b0;
    logic        drv = 1'b1;
`ifdef UART_XCVR_PARITY_EN
    logic [1:0]  parity_mode = 2'b00;
    logic        rx_parity_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_fe = 0;
    int n_ov = 0;
    int n_pe = 0;
    logic [7:0] exp_q[$];
    logic       exp_bits[$];

    assign ser_rxd = lb ? ser_txd : drv;

    uart_xcvr #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clk(clk), .resetn(resetn), .divisor(divisor),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ser_txd(ser_txd), .ser_rxd(ser_rxd), .tx_busy(tx_busy),
        .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
`ifdef UART_XCVR_PARITY_EN
        , .parity_mode(parity_mode), .rx_parity_err(rx_parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_frame_err) n_fe <= n_fe + 1;
        if (rx_overrun) n_ov <= n_ov + 1;
`ifdef UART_XCVR_PARITY_EN
        if (rx_parity_err) n_pe <= n_pe + 1;
`endif
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        int w = 0;
        while (!tx_ready && w < 20000) begin
            tick();
            w++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pb,
                              input logic stop, input int div);
        drv = 1'b0;
        tick(div);
        for (int i = 0; i < 8; i++) begin
            drv = d[i];
            tick(div);
        end
        if (has_par) begin
            drv = pb;
            tick(div);
        end
        drv = stop;
        tick(div);
    endtask

    task automatic wait_rx(input int budget);
        int w = 0;
        while (!rx_valid && w < budget) begin
            tick();
            w++;
        end
    endtask

    task automatic test_reset;
        tick(3);
        n_cmp++;
        if (ser_txd !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs txd=%b tx_ready=%b rx_valid=%b tx_busy=%b, required 1 1 0 0",
                     ser_txd, tx_ready, rx_valid, tx_busy);
        end
        n_cmp++;
        if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0 || rx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rx fe=%b ov=%b rx_data=%h, required 0 0 00",
                     rx_frame_err, rx_overrun, rx_data);
        end
        resetn = 1'b1;
        tick(2);
    endtask

    task automatic test_basic_tx;
        logic [7:0] ch = 8'h55;
        logic e;
        divisor = 16'd16;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(ch[i]);
        exp_bits.push_back(1'b1);
        push_tx(ch);
        push_tx(8'hA0);
        n_cmp++;
        if (ser_txd !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_latency_early txd=%b at N+1, required 1", ser_txd);
        end
        tick();
        n_cmp++;
        if (ser_txd !== 1'b0 || tx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_start_edge txd=%b busy=%b at N+2, required 0 1", ser_txd, tx_busy);
        end
        tick(8);
        for (int b = 0; b < 10; b++) begin
            e = exp_bits.pop_front();
            n_cmp++;
            if (ser_txd !== e) begin
                n_bad++;
                $display("FAIL tx_bit%0d txd=%b, required %b", b, ser_txd, e);
            end
            if (b < 9) tick(16);
        end
        tick(7);
        n_cmp++;
        if (ser_txd !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_stop_end txd=%b at N+161, required 1", ser_txd);
        end
        tick(2);
        n_cmp++;
        if (ser_txd !== 1'b0) begin
            n_bad++;
            $display("FAIL tx_back_to_back txd=%b at N+163, required 0", ser_txd);
        end
        tick(170);
        n_cmp++;
        if (ser_txd !== 1'b1 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL tx_idle_after txd=%b busy=%b, required 1 0", ser_txd, tx_busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        divisor = 16'd16;
        push_tx(8'h00);
        tick(2);
        n_cmp++;
        if (ser_txd !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_pre txd=%b, required 0", ser_txd);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if (ser_txd !== 1'b1 || tx_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_async txd=%b busy=%b, required 1 0", ser_txd, tx_busy);
        end
        tick(2);
        resetn = 1'b1;
        tick(40);
        n_cmp++;
        if (ser_txd !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_after txd=%b, required 1", ser_txd);
        end
    endtask

    task automatic test_loopback;
        logic [7:0] e;
        int fe0 = n_fe;
        int ov0 = n_ov;
        divisor = 16'd430;
        lb = 1'b1;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(8'hA3);
        push_tx(8'hA3);
        exp_q.push_back(8'h00);
        push_tx(8'h00);
        exp_q.push_back(8'hFF);
        push_tx(8'hFF);
        for (int k = 0; k < 3; k++) begin
            wait_rx(6000);
            e = exp_q.pop_front();
            n_cmp++;
            if (rx_valid !== 1'b1 || rx_data !== e) begin
                n_bad++;
                $display("FAIL loopback%0d rx_valid=%b rx_data=%h, required 1 %h", k, rx_valid, rx_data, e);
            end
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        tick(500);
        n_cmp++;
        if (n_fe != fe0 || n_ov != ov0 || rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL loopback_clean fe=%0d ov=%0d rx_valid=%b, required %0d %0d 0",
                     n_fe, n_ov, rx_valid, fe0, ov0);
        end
        lb = 1'b0;
    endtask

    task automatic test_false_start;
        int fe0 = n_fe;
        divisor = 16'd430;
        drv = 1'b0;
        tick(100);
        drv = 1'b1;
        tick(6000);
        n_cmp++;
        if (rx_valid !== 1'b0 || n_fe != fe0) begin
            n_bad++;
            $display("FAIL false_start rx_valid=%b fe=%0d, required 0 %0d", rx_valid, n_fe, fe0);
        end
    endtask

    task automatic test_frame_error;
        logic [7:0] e;
        int fe0 = n_fe;
        divisor = 16'd430;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 430);
        tick(3 * 430);
        drv = 1'b1;
        tick(2 * 430);
        n_cmp++;
        if (n_fe != fe0 + 1 || rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_err pulses=%0d rx_valid=%b, required %0d 0", n_fe - fe0, rx_valid, 1);
        end
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 430);
        wait_rx(2000);
        e = exp_q.pop_front();
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== e || n_fe != fe0 + 1) begin
            n_bad++;
            $display("FAIL frame_err_recover rx_valid=%b rx_data=%h pulses=%0d, required 1 %h 1",
                     rx_valid, rx_data, n_fe - fe0, e);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic test_overrun;
        logic [7:0] e;
        int ov0 = n_ov;
        divisor = 16'd430;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(8'h31 + 8'(i * 17));
            send_frame(8'h31 + 8'(i * 17), 1'b0, 1'b0, 1'b1, 430);
        end
        tick(50);
        n_cmp++;
        if (n_ov != ov0 + 1 || tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_pulses got=%0d, required 1", n_ov - ov0);
        end
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rx_valid !== 1'b1 || rx_data !== e) begin
                n_bad++;
                $display("FAIL overrun_fifo%0d rx_valid=%b rx_data=%h, required 1 %h", k, rx_valid, rx_data, e);
            end
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        n_cmp++;
        if (rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_drained rx_valid=%b, required 0", rx_valid);
        end
    endtask

`ifdef UART_XCVR_PARITY_EN
    task automatic test_parity;
        logic [7:0] ch = 8'h07;
        logic e;
        int pe0 = n_pe;
        divisor = 16'd16;
        parity_mode = 2'b01;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(ch[i]);
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1);
        push_tx(ch);
        tick(9);
        for (int b = 0; b < 11; b++) begin
            e = exp_bits.pop_front();
            n_cmp++;
            if (ser_txd !== e) begin
                n_bad++;
                $display("FAIL par_tx_bit%0d txd=%b, required %b", b, ser_txd, e);
            end
            tick(16);
        end
        tick(40);
        exp_q.push_back(ch);
        send_frame(ch, 1'b1, 1'b0, 1'b1, 16);
        wait_rx(100);
        tick(2);
        e = 1'b0;
        n_cmp++;
        if (n_pe != pe0 + 1 || rx_valid !== 1'b1 || rx_data !== exp_q[0]) begin
            n_bad++;
            $display("FAIL parity_rx pulses=%0d rx_valid=%b rx_data=%h, required 1 1 %h",
                     n_pe - pe0, rx_valid, rx_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        parity_mode = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_tx();
        test_reset_mid_frame();
        test_loopback();
        test_false_start();
        test_frame_error();
        test_overrun();
`ifdef UART_XCVR_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
